instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch-side initiator for the synchronous-read instruction_memory. It generates word addresses from a program counter and captures the returned instruction one clock later. Instructions are buffered in a small queue and handed to decode over a valid/ready handshake. Branch redirects flush all stale instructions.

Parameters:
ADDR_W, 16, width of the PC and of imem_address.
INSTR_W, 16, instruction word width.
MEM_DEPTH, 32, number of instruction words; power of 2; the PC wraps modulo MEM_DEPTH.
QUEUE_DEPTH, 2, number of instruction-queue entries (>=2).
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
imem_address  output  ADDR_W  word address to instruction_memory; driven directly from the pc_q register.
imem_instruction  input  INSTR_W  registered read data from instruction_memory (memory[address] captured on the previous edge).
branch_valid  input  1  redirect request, sampled on the rising edge.
branch_target  input  ADDR_W  redirect word address.
if_valid  output  1  queue head holds a valid instruction.
if_ready  input  1  decode accepts the head this cycle.
if_instruction  output  INSTR_W  queue head instruction.
if_pc  output  ADDR_W  word address of the queue head.

Behaviour:
- Reset (reset=0, asynchronous): pc_q=RESET_PC, inflight_v=0, queue count=0.
  - Output values during reset: imem_address=RESET_PC, if_valid=0, if_instruction=0, if_pc=0.
  - Reset asserted mid-operation discards the queue and any in-flight fetch immediately.
- Fetch pipeline: imem_address=pc_q at all times.
- Issue at edge E:
  - Condition: (count + inflight_v - pop) < QUEUE_DEPTH and no branch_valid, where pop = if_valid & if_ready.
  - Effect: inflight_v<=1, inflight_pc<=pc_q, pc_q<=(pc_q+1) mod MEM_DEPTH.
  - Otherwise inflight_v<=0 and pc_q holds.
- Capture at edge E+1: if inflight_v=1, {imem_instruction, inflight_pc} is pushed into the queue tail. Fetch-to-queue latency is 1 cycle.
- Queue output:
  - Queue-only output path; no bypass from imem_instruction to if_*.
  - if_valid=(count!=0). if_instruction and if_pc come from the head.
  - Head and tail pointers wrap modulo QUEUE_DEPTH.
- Handshake: a transfer occurs at an edge with if_valid=1 and if_ready=1.
  - if_instruction and if_pc hold stable while if_valid=1 and if_ready=0.
  - if_ready while if_valid=0 has no effect.
- Full: no issue when the queue plus in-flight entry would exceed QUEUE_DEPTH. No instruction is ever dropped or duplicated.
- Simultaneous push+pop at full or at count=1: both take effect, count unchanged.
- Branch at edge E (branch_valid=1):
  - A handshake in that same cycle still counts as consumed.
  - All remaining queue entries are flushed (count<=0).
  - inflight_v<=0, so data arriving at E+1 is discarded.
  - pc_q<=branch_target mod MEM_DEPTH (low log2(MEM_DEPTH) bits). No issue occurs at E.
  - The target is issued at E+1, queued at E+2, and if_valid=1 after E+2.
- Back-to-back branches: the last one wins; each flushes again.
- Wrap-around: PC MEM_DEPTH-1 is followed by 0. imem_address never exceeds MEM_DEPTH-1, so reads never go out of range.
- Steady state with if_ready=1 constant: one instruction per cycle, sequential PCs.

Decomposition:
- Shared definitions file cpu_defs: ADDR_W, INSTR_W, MEM_DEPTH, RESET_PC, and the derived pointer width clog2(MEM_DEPTH).
- One sub-module, fetch_queue:
  - Synchronous FIFO of {pc, instruction}, QUEUE_DEPTH entries.
  - Ports: push, pop, flush, count, full/empty.
  - Same clock/reset convention.
  - flush has priority over push; a pop in the flush cycle is legal.
- Top level holds pc_q, the in-flight register and issue logic.

Test Plan:
- Bench memory image: memory[i]=16'hA000+i. Release reset, if_ready=1 -> if_valid rises after edge 2, then the if_pc/if_instruction stream is 0/A000, 1/A001, 2/A002... at one per cycle.
- Hold if_ready=0 for 10 cycles after the first valid -> count saturates at 2, the head stays 0/A000, and imem_address stops advancing at 2. Release -> 0, 1, 2, 3 in order with no gaps or duplicates.
- branch_valid with target=20 while the queue holds PCs 5,6 and PC 7 is in flight -> 5, 6 and 7 are never presented. The next if_valid is 20/A014, two cycles after the branch edge, followed by 21, 22.
- branch_target=16'h0045 -> fetch starts at PC 5 (mod 32). Running sequentially from PC 30 -> 30, 31, 0, 1.
- Assert reset for 1 cycle mid-stream with the queue full -> if_valid=0 immediately (asynchronously), and after release the stream restarts at RESET_PC.
- Random if_ready (50%) with random branches over 2000 cycles -> a scoreboard model predicts every if_pc/if_instruction pair exactly, with no loss.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU fetch definitions: default widths, memory size and reset PC.
package instruction_fetch_unit_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_INSTR_W     = 16;
  localparam int DEF_MEM_DEPTH   = 32;
  localparam int DEF_QUEUE_DEPTH = 2;
  localparam int DEF_RESET_PC    = 0;

  // Number of PC bits that actually address the instruction memory.
  localparam int DEF_PC_BITS     = $clog2(DEF_MEM_DEPTH);

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// Flush wins over push; a pop in the flush cycle is harmless.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = DEF_QUEUE_DEPTH,
  parameter int DATA_W = DEF_ADDR_W + DEF_INSTR_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_pop      = pop_i & ~empty_o;
  assign do_push     = push_i & (~full_o | do_pop) & ~flush_i;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: it is only read while count_q says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: drives the PC into a synchronous-read instruction memory,
// captures the returned word one cycle later and queues it for decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int RESET_PC    = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int               CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int               ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               inflight_v_q;
  logic               issue, pop;
  logic [CNT_W-1:0]   q_count;
  logic               q_full, q_empty;
  logic [ENTRY_W-1:0] q_head;

  assign pop          = ~q_empty & if_ready;
  assign imem_address = pc_q;

  // Issue only if the word coming back next cycle is guaranteed a queue slot.
  always_comb begin
    issue = 1'b0;
    if (!branch_valid && (!q_full || pop) &&
        (int'(q_count) + int'(inflight_v_q) - int'(pop) < QUEUE_DEPTH)) begin
      issue = 1'b1;
    end
  end

  // Next PC: a redirect overrides sequential fetch; both wrap to the memory size.
  always_comb begin
    pc_d = pc_q;
    if (branch_valid)  pc_d = branch_target & PC_MASK;
    else if (issue)    pc_d = (pc_q + ADDR_W'(1)) & PC_MASK;
  end

  // PC and in-flight tracking; a redirect kills the in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_v_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (ENTRY_W),
    .CNT_W  (CNT_W)
  ) u_fetch_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (branch_valid),
    .push_i      (inflight_v_q),
    .push_data_i ({inflight_pc_q, imem_instruction}),
    .pop_i       (pop),
    .head_data_o (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign if_valid       = ~q_empty;
  assign if_pc          = if_valid ? q_head[ENTRY_W-1 -: ADDR_W] : '0;
  assign if_instruction = if_valid ? q_head[INSTR_W-1:0] : '0;

endmodule
